// File: rtl/ray_job_pkg.sv
// Shared widths and the packed ray job record for the ray job receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ray_job_pkg;

  localparam int X_BITS         = 5;   // voxel X index width
  localparam int Y_BITS         = 5;   // voxel Y index width
  localparam int Z_BITS         = 5;   // voxel Z index width
  localparam int W              = 24;  // DDA fixed-point width for next_*/inc_*
  localparam int MAX_STEPS_BITS = 10;  // step-limit width

  // One traversal job: start voxel, step signs, initial tMax and tDelta per axis.
  typedef struct packed {
    logic [X_BITS-1:0]         ix0;
    logic [Y_BITS-1:0]         iy0;
    logic [Z_BITS-1:0]         iz0;
    logic                      sx;
    logic                      sy;
    logic                      sz;
    logic [W-1:0]              next_x;
    logic [W-1:0]              next_y;
    logic [W-1:0]              next_z;
    logic [W-1:0]              inc_x;
    logic [W-1:0]              inc_y;
    logic [W-1:0]              inc_z;
    logic [MAX_STEPS_BITS-1:0] max_steps;
  } ray_job_t;

endpackage

// File: rtl/ray_job_rx_if.sv
// Pin bundle between the job producer, ray_job_rx and the traversal core.
// Latency: n/a (wiring only).
// Backpressure: job side is pulse + advisory ready; out side is valid/ready.
// Ports: producer side load_mode/job_valid/job_ready/job fields; consumer side
//        out_valid/out_ready/out_job/out_id; status overflow/jobs_accepted/occupancy.
interface ray_job_rx_if
  import ray_job_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ID_BITS = 16
) ();

  logic                       load_mode;
  logic                       job_valid;
  logic                       job_ready;
  logic [X_BITS-1:0]          ix0;
  logic [Y_BITS-1:0]          iy0;
  logic [Z_BITS-1:0]          iz0;
  logic                       sx;
  logic                       sy;
  logic                       sz;
  logic [W-1:0]               next_x;
  logic [W-1:0]               next_y;
  logic [W-1:0]               next_z;
  logic [W-1:0]               inc_x;
  logic [W-1:0]               inc_y;
  logic [W-1:0]               inc_z;
  logic [MAX_STEPS_BITS-1:0]  max_steps;

  logic                       out_valid;
  logic                       out_ready;
  ray_job_t                   out_job;
  logic [ID_BITS-1:0]         out_id;

  logic                       overflow;
  logic [31:0]                jobs_accepted;
  logic [$clog2(DEPTH):0]     occupancy;

  // Receiver view.
  modport slave (
    input  load_mode, job_valid, ix0, iy0, iz0, sx, sy, sz,
           next_x, next_y, next_z, inc_x, inc_y, inc_z, max_steps, out_ready,
    output job_ready, out_valid, out_job, out_id, overflow, jobs_accepted, occupancy
  );

  // Producer + consumer view.
  modport master (
    output load_mode, job_valid, ix0, iy0, iz0, sx, sy, sz,
           next_x, next_y, next_z, inc_x, inc_y, inc_z, max_steps, out_ready,
    input  job_ready, out_valid, out_job, out_id, overflow, jobs_accepted, occupancy
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic first-word fall-through FIFO with synchronous active-low reset.
// Latency: a push into an empty FIFO is visible on o_rdat/!o_empty the next cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: i_push/i_wdat write side, i_pop/o_rdat read side, o_full/o_empty/o_count status.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

  // A pop in the same cycle frees the slot the push needs, so full does not block it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Empty reads as zero so the head output is clean after reset and between jobs.
  assign o_rdat = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/ray_job_rx.sv
// Receives one-cycle ray job pulses, tags them with a sequence ID and queues them for the traversal core.
// Latency: a job pulsed into an empty queue shows on out_valid one cycle later.
// Backpressure: job_ready drops early (READY_MARGIN free slots) to absorb in-flight pulses; out side holds until out_ready.
// Ports: clk, rst_n (sync, active low), bus (ray_job_rx_if.slave: job input, head output, status).
module ray_job_rx
  import ray_job_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int READY_MARGIN = 2,
  parameter int ID_BITS      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  ray_job_rx_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int JW = $bits(ray_job_t);
  localparam int FW = JW + ID_BITS;

  ray_job_t           w_in_job;
  logic [FW-1:0]      w_wdat;
  logic [FW-1:0]      w_rdat;
  logic               w_full;
  logic               w_empty;
  logic               w_push_acc;
  logic               w_pop_acc;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_occ_next;
  logic [CW-1:0]      w_free_next;

  logic [ID_BITS-1:0] r_id;
  logic [31:0]        r_jobs_accepted;
  logic               r_overflow;
  logic               r_job_ready;

  always_comb begin
    w_in_job           = '0;
    w_in_job.ix0       = bus.ix0;
    w_in_job.iy0       = bus.iy0;
    w_in_job.iz0       = bus.iz0;
    w_in_job.sx        = bus.sx;
    w_in_job.sy        = bus.sy;
    w_in_job.sz        = bus.sz;
    w_in_job.next_x    = bus.next_x;
    w_in_job.next_y    = bus.next_y;
    w_in_job.next_z    = bus.next_z;
    w_in_job.inc_x     = bus.inc_x;
    w_in_job.inc_y     = bus.inc_y;
    w_in_job.inc_z     = bus.inc_z;
    w_in_job.max_steps = bus.max_steps;
  end

  // The ID rides alongside the job so it leaves with the matching entry.
  assign w_wdat = {w_in_job, r_id};

  // Mirrors the FIFO's own acceptance rule; every job_valid is a push request,
  // whatever job_ready said, because the producer's pulse lags its ready sample.
  assign w_pop_acc  = bus.out_ready && !w_empty;
  assign w_push_acc = bus.job_valid && (!w_full || w_pop_acc);

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.job_valid),
    .i_wdat  (w_wdat),
    .i_pop   (bus.out_ready),
    .o_rdat  (w_rdat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Ready is decided from next-cycle occupancy so it is valid the moment it registers.
  assign w_occ_next  = w_count + CW'(w_push_acc) - CW'(w_pop_acc);
  assign w_free_next = CW'(DEPTH) - w_occ_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id            <= '0;
      r_jobs_accepted <= '0;
      r_overflow      <= 1'b0;
      r_job_ready     <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_id            <= r_id + ID_BITS'(1);
        r_jobs_accepted <= r_jobs_accepted + 32'd1;
      end
      if (bus.job_valid && !w_push_acc) begin
        r_overflow <= 1'b1;
      end
      r_job_ready <= !bus.load_mode && (w_free_next >= CW'(READY_MARGIN));
    end
  end

  assign bus.job_ready     = r_job_ready;
  assign bus.out_valid     = !w_empty;
  assign bus.out_job       = ray_job_t'(w_rdat[FW-1:ID_BITS]);
  assign bus.out_id        = w_rdat[ID_BITS-1:0];
  assign bus.overflow      = r_overflow;
  assign bus.jobs_accepted = r_jobs_accepted;
  assign bus.occupancy     = w_count;

endmodule
